// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - burst accumulator of 9-bit adder sums with in/out handshakes
// Sums NUM_SAMPLES operands {cy_in,sum_in} into acc_out with a sticky overflow flag.
module sum_accumulator #(
  parameter int ACC_W       = 16,
  parameter int NUM_SAMPLES = 4,
  localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       sum_in,
  input  logic             cy_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t           state;
  logic             take;
  logic [ACC_W:0]   acc_sum;

  // in_ready is registered and high only in ACCUM, so take implies ACCUM
  assign take    = in_valid & in_ready;
  assign acc_sum = {1'b0, acc_out} + {{(ACC_W - 8){1'b0}}, cy_in, sum_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= '0;
      overflow  <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (take) begin
            acc_out  <= acc_sum[ACC_W-1:0];
            overflow <= overflow | acc_sum[ACC_W];
            count    <= count + CNT_W'(1);
            if (count == LAST_IDX) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
